// File: rtl/fir_pkg.sv
// fir_pkg: shared sample width, FIR round length and feeder state encoding
package fir_pkg;
    localparam int WI        = 2;
    localparam int WF        = 10;
    localparam int SAMPLE_W  = WI + WF;
    localparam int CYCLE_NUM = 4;
    typedef enum logic [1:0] {
        F_IDLE  = 2'b00,
        F_ISSUE = 2'b01,
        F_WAIT  = 2'b10
    } feed_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered pointers and occupancy over distributed-RAM storage
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;
    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign rdata_o = mem[rd_ptr_q];
    // gating here guarantees neither pointer can overrun the other
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers source samples and hands them to the time-multiplexed FIR one round at a time
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int WI      = 2,
    parameter int WF      = 10,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 32,
    parameter int LW      = $clog2(DEPTH) + 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic signed [WI+WF-1:0]    s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic signed [WI+WF-1:0]    x_o,
    output logic                       in_valid_o,
    input  logic                       fir_out_valid_i,
    output logic [LW-1:0]              level_o,
    output logic                       busy_o,
    output logic                       ovf_o,
    output logic                       tmo_err_o
);
    localparam int SW = WI + WF;
    localparam int WW = $clog2(TIMEOUT);
    if (TIMEOUT <= CYCLE_NUM + 2) begin : g_bad_timeout
        $error("TIMEOUT must exceed CYCLE_NUM+2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2, at least 2");
    end
    feed_state_t    state_q;
    logic [SW-1:0]  x_q, rdata;
    logic [WW-1:0]  wd_q;
    logic           in_valid_q, ovf_q, tmo_q, full, empty, pop;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(SW), .LW(LW)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (s_valid_i),
        .pop_i   (pop),
        .wdata_i (s_data_i),
        .rdata_o (rdata),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );
    assign pop        = state_q == F_IDLE && !empty;
    assign s_ready_o  = !full;
    assign x_o        = x_q;
    assign in_valid_o = in_valid_q;
    assign busy_o     = state_q != F_IDLE;
    assign ovf_o      = ovf_q;
    assign tmo_err_o  = tmo_q;
    // x only changes on the IDLE load, so it is stable through the FIR's shift edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= F_IDLE;
            x_q        <= '0;
            in_valid_q <= 1'b0;
            wd_q       <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            if (s_valid_i && full) ovf_q <= 1'b1;
            case (state_q)
                F_IDLE: if (!empty) begin
                    x_q        <= rdata;
                    in_valid_q <= 1'b1;
                    state_q    <= F_ISSUE;
                end
                F_ISSUE: begin
                    in_valid_q <= 1'b0;
                    wd_q       <= '0;
                    state_q    <= F_WAIT;
                end
                F_WAIT: if (fir_out_valid_i) state_q <= F_IDLE;
                else if (wd_q == WW'(TIMEOUT - 1)) begin
                    tmo_q   <= 1'b1;
                    state_q <= F_IDLE;
                end else wd_q <= wd_q + 1'b1;
                default: state_q <= F_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: randomized stimulus against a queue-based model of the feeder, plus literal pins
module tb_fir_sample_feeder;
    localparam int DEPTH = 16, TIMEOUT = 32, LW = 5;
    logic CLK = 1'b1, RST = 1'b1;
    logic s_valid_i = 1'b0, fir_out_valid_i = 1'b0;
    logic [11:0] s_data_i = '0;
    logic s_ready_o, in_valid_o, busy_o, ovf_o, tmo_err_o;
    logic [11:0] x_o;
    logic [LW-1:0] level_o;
    fir_sample_feeder #(.WI(2), .WF(10), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .LW(LW)) dut (
        .CLK(CLK), .RST(RST), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .x_o(x_o), .in_valid_o(in_valid_o), .fir_out_valid_i(fir_out_valid_i), .level_o(level_o),
        .busy_o(busy_o), .ovf_o(ovf_o), .tmo_err_o(tmo_err_o)
    );
    always #5 CLK = ~CLK;
    int n_tests = 0, n_fail = 0, cyc = 0, fcnt = 100, t0, pk;
    bit fir_run = 1'b0;
    int iv_cyc[$];
    logic [11:0] iv_x[$], sent[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // one cycle: inputs for this cycle applied just after the edge; FIR responder answers 6 cycles after in_valid
    task automatic step(input logic v, input logic [11:0] d);
        @(posedge CLK);
        #1;
        cyc++;
        s_valid_i = v;
        s_data_i  = d;
        fcnt = in_valid_o ? 0 : fcnt + 1;
        fir_out_valid_i = fir_run && fcnt == 6;
        if (in_valid_o) begin
            iv_cyc.push_back(cyc);
            iv_x.push_back(x_o);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask
    task automatic do_reset();
        RST = 1'b1;
        step(1'b0, '0);
        RST = 1'b0;
    endtask
    task automatic clr();
        iv_cyc.delete();
        iv_x.delete();
        sent.delete();
    endtask
    // model: queue of waiting samples plus one outstanding sample aged in cycles since its issue
    logic [11:0] mq[$];
    logic [11:0] mx;
    bit m_ok = 1'b0, mout, movf, mtmo, mpop, mpush;
    int mage;
    always @(negedge CLK) begin
        if (m_ok) begin
            check("in_valid", in_valid_o, mout && mage == 0);
            check("x", x_o, mx);
            check("level", level_o, mq.size());
            check("s_ready", s_ready_o, mq.size() != DEPTH);
            check("busy", busy_o, mout);
            check("ovf", ovf_o, movf);
            check("tmo_err", tmo_err_o, mtmo);
        end
        if (RST) begin
            mq.delete();
            mx = '0; mout = 0; mage = 0; movf = 0; mtmo = 0; m_ok = 1;
        end else if (m_ok) begin
            mpop  = !mout && mq.size() > 0;
            mpush = s_valid_i && mq.size() != DEPTH;
            if (s_valid_i && !mpush) movf = 1;
            if (mout) begin
                if (mage == 0) mage = 1;
                else if (fir_out_valid_i) mout = 0;
                else if (mage == TIMEOUT) begin mtmo = 1; mout = 0; end
                else mage++;
            end
            if (mpop) begin mx = mq.pop_front(); mout = 1; mage = 0; end
            if (mpush) mq.push_back(s_data_i);
        end
    end
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end
    initial begin
        do_reset();
        check("rst_level", level_o, 0);
        check("rst_x", x_o, 0);
        check("rst_ready", s_ready_o, 1);
        // single sample
        fir_run = 1; clr();
        step(1'b1, 12'h155); t0 = cyc;
        step(1'b0, '0);
        check("single_lvl1", level_o, 1);
        step(1'b0, '0);
        check("single_iv", in_valid_o, 1);
        check("single_x", x_o, 12'h155);
        idle(20);
        check("single_npulse", iv_cyc.size(), 1);
        if (iv_cyc.size() > 0) check("single_lat", iv_cyc[0] - t0, 2);
        check("single_lvl0", level_o, 0);
        // burst of 5 with FIR responder running
        clr(); pk = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 12'(i));
            if (int'(level_o) > pk) pk = level_o;
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b0, '0);
            if (int'(level_o) > pk) pk = level_o;
        end
        check("burst_n", iv_x.size(), 5);
        check("burst_peak", pk, 4);
        for (int i = 0; i < iv_x.size(); i++) begin
            check("burst_x", iv_x[i], i + 1);
            if (i > 0) check("burst_gap", iv_cyc[i] - iv_cyc[i-1], 8);
        end
        // overflow with stalled FIR
        fir_run = 0; clr();
        for (int i = 0; i < 17; i++) step(1'b1, 12'h100 + 12'(i));
        step(1'b1, 12'hFFF);
        check("ovf_ready", s_ready_o, 0);
        check("ovf_level", level_o, 16);
        step(1'b0, '0);
        check("ovf_flag", ovf_o, 1);
        fir_run = 1;
        idle(250);
        check("ovf_n", iv_x.size(), 17);
        for (int i = 0; i < iv_x.size(); i++) check("ovf_x", iv_x[i], 12'h100 + i);
        check("ovf_tmo", tmo_err_o, 1);
        // wrap-around stream with random data and gaps
        do_reset(); clr(); fir_run = 1;
        for (int i = 0; i < 40; i++) begin
            sent.push_back(12'($urandom));
            step(1'b1, sent[i]);
            if (i >= 10) idle($urandom_range(7, 11));
        end
        idle(200);
        check("wrap_n", iv_x.size(), 40);
        for (int i = 0; i < iv_x.size() && i < 40; i++) check("wrap_x", iv_x[i], sent[i]);
        check("wrap_ovf", ovf_o, 0);
        // timeout on a negative sample
        do_reset(); clr(); fir_run = 0;
        step(1'b1, 12'hA00);
        step(1'b1, 12'h123);
        step(1'b0, '0);
        for (int i = 0; i < 100 && !tmo_err_o; i++) step(1'b0, '0);
        check("tmo_seen", tmo_err_o, 1);
        if (iv_cyc.size() > 0) begin
            check("tmo_x0", iv_x[0], 12'hA00);
            check("tmo_lat", cyc - iv_cyc[0], 33);
        end
        idle(5);
        check("tmo_next_n", iv_x.size(), 2);
        if (iv_x.size() > 1) begin
            check("tmo_next_x", iv_x[1], 12'h123);
            check("tmo_next_gap", iv_cyc[1] - iv_cyc[0], 34);
        end
        // reset while waiting with 3 queued
        do_reset(); clr(); fir_run = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 12'h200 + 12'(i));
        idle(40);
        check("mid_busy", busy_o, 1);
        check("mid_level", level_o, 3);
        check("mid_tmo", tmo_err_o, 1);
        do_reset();
        check("rst2_level", level_o, 0);
        check("rst2_x", x_o, 0);
        check("rst2_iv", in_valid_o, 0);
        check("rst2_busy", busy_o, 0);
        check("rst2_ovf", ovf_o, 0);
        check("rst2_tmo", tmo_err_o, 0);
        clr();
        idle(20);
        check("rst2_quiet", iv_x.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
